// File: rtl/instruction_fetch.sv
// instruction_fetch
// -----------------
// Fetch stage front end between the program counter and decode. It issues one
// single-word Wishbone-classic read per instruction. It hands the returned word to
// decode over a valid/ready handshake. It pulses pc_count when decode takes the
// word, so the program counter advances.
//
// Ports
//   clk, reset   : clock and synchronous active-high reset
//   pc           : current program counter (byte address)
//   pc_count     : advance PC by 4 (combinational, one-cycle pulse)
//   flush        : redirect, discard any in-flight or held fetch
//   mem_cyc/stb  : bus cycle / strobe (always asserted together)
//   mem_adr      : word-aligned byte address of the read
//   mem_dat_r    : read data, valid while mem_ack is high
//   mem_ack      : read acknowledge
//   instr        : fetched word (NOP_INSTR when faulted)
//   instr_pc     : PC the instruction was fetched from
//   instr_fault  : misaligned PC or bus timeout
//   instr_valid  : instr/instr_pc/instr_fault are valid
//   instr_ready  : decode accepts this cycle
module instruction_fetch #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] NOP_INSTR      = 32'h00000013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic        pc_count,
  input  logic        flush,
  output logic        mem_cyc,
  output logic        mem_stb,
  output logic [31:0] mem_adr,
  input  logic [31:0] mem_dat_r,
  input  logic        mem_ack,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_fault,
  output logic        instr_valid,
  input  logic        instr_ready
);

  // The counter only has to reach TIMEOUT_CYCLES-1. Keep at least one bit so
  // the design still elaborates when the timeout is disabled.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_COUNT =
    CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD,
    HOLD
  } state_t;

  state_t      state_q, state_n;
  logic        bus_q, bus_n;
  logic [31:0] adr_q, adr_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] instr_pc_q, instr_pc_n;
  logic        fault_q, fault_n;
  logic        valid_q, valid_n;
  logic [CW-1:0] count_q, count_n;
  logic        timeout_hit;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count_q == LAST_COUNT);

  assign mem_cyc     = bus_q;
  assign mem_stb     = bus_q;
  assign mem_adr     = adr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_fault = fault_q;
  assign instr_valid = valid_q;

  // The word leaves on the same edge the program counter steps. A redirect
  // suppresses the step because execute is loading the PC in that cycle.
  assign pc_count = valid_q & instr_ready & ~flush;

  // State and output registers. A reset drops the bus cycle at once. The
  // interconnect shares this reset, so no stale ack follows.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bus_q      <= 1'b0;
      adr_q      <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      fault_q    <= 1'b0;
      valid_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      state_q    <= state_n;
      bus_q      <= bus_n;
      adr_q      <= adr_n;
      instr_q    <= instr_n;
      instr_pc_q <= instr_pc_n;
      fault_q    <= fault_n;
      valid_q    <= valid_n;
      count_q    <= count_n;
    end
  end

  // Next-state and next-output logic. Every register holds its value unless
  // a state below changes it. This keeps adr/stb stable while a request waits.
  always_comb begin
    state_n    = state_q;
    bus_n      = bus_q;
    adr_n      = adr_q;
    instr_n    = instr_q;
    instr_pc_n = instr_pc_q;
    fault_n    = fault_q;
    valid_n    = valid_q;
    count_n    = count_q;

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          state_n = IDLE;
        end else if (pc[1:0] != 2'b00) begin
          // A misaligned PC never reaches the bus. Report it as a faulted
          // word so decode can raise the exception in program order.
          state_n    = HOLD;
          instr_n    = NOP_INSTR;
          instr_pc_n = pc;
          fault_n    = 1'b1;
          valid_n    = 1'b1;
        end else begin
          state_n    = REQ;
          bus_n      = 1'b1;
          adr_n      = pc;
          instr_pc_n = pc;
          count_n    = '0;
        end
      end

      REQ: begin
        count_n = count_q + 1'b1;
        if (mem_ack && !flush) begin
          state_n = HOLD;
          bus_n   = 1'b0;
          instr_n = mem_dat_r;
          fault_n = 1'b0;
          valid_n = 1'b1;
        end else if (mem_ack) begin
          state_n = IDLE;
          bus_n   = 1'b0;
        end else if (flush) begin
          // The slave is already committed to this read. Keep the strobe up
          // until it answers, then throw the data away.
          state_n = DISCARD;
        end else if (timeout_hit) begin
          state_n = HOLD;
          bus_n   = 1'b0;
          instr_n = NOP_INSTR;
          fault_n = 1'b1;
          valid_n = 1'b1;
        end
      end

      DISCARD: begin
        count_n = count_q + 1'b1;
        if (mem_ack || timeout_hit) begin
          state_n = IDLE;
          bus_n   = 1'b0;
        end
      end

      HOLD: begin
        if (flush || instr_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch
// --------------------
// Scoreboard bench for instruction_fetch. Each PC the bench presents pushes the
// word it should yield. Every pc_count pulse pops the front entry and compares
// instr/instr_pc/instr_fault. A second instance with a short timeout and a
// silent bus covers the fetch timeout.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        reset_to;
  logic [31:0] pc;
  logic        flush;
  logic        instr_ready;
  logic [31:0] mem_dat_r;
  logic        mem_ack;

  logic        pc_count;
  logic        mem_cyc;
  logic        mem_stb;
  logic [31:0] mem_adr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_fault;
  logic        instr_valid;

  logic        pc_count_to;
  logic        mem_cyc_to;
  logic        mem_stb_to;
  logic [31:0] mem_adr_to;
  logic [31:0] instr_to;
  logic [31:0] instr_pc_to;
  logic        instr_fault_to;
  logic        instr_valid_to;

  exp_t sb[$];
  int   check_count;
  int   error_count;
  int   accept_count;
  bit   adv_pending;
  int   ack_delay;
  int   wait_cnt;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .pc_count    (pc_count),
    .flush       (flush),
    .mem_cyc     (mem_cyc),
    .mem_stb     (mem_stb),
    .mem_adr     (mem_adr),
    .mem_dat_r   (mem_dat_r),
    .mem_ack     (mem_ack),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_fault (instr_fault),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  instruction_fetch #(.TIMEOUT_CYCLES(4)) dut_to (
    .clk         (clk),
    .reset       (reset_to),
    .pc          (pc),
    .pc_count    (pc_count_to),
    .flush       (flush),
    .mem_cyc     (mem_cyc_to),
    .mem_stb     (mem_stb_to),
    .mem_adr     (mem_adr_to),
    .mem_dat_r   (32'h0),
    .mem_ack     (1'b0),
    .instr       (instr_to),
    .instr_pc    (instr_pc_to),
    .instr_fault (instr_fault_to),
    .instr_valid (instr_valid_to),
    .instr_ready (instr_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents seen by the bus responder and by the expectation model.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: mem_word = 32'hDEADBEEF;
      32'h0000_0010: mem_word = 32'h12345678;
      default:       mem_word = {~a[15:0], a[15:0]};
    endcase
  endfunction

  function automatic exp_t exp_for(input logic [31:0] p);
    exp_t e;
    if (p[1:0] != 2'b00) begin
      e.instr = NOP;
      e.fault = 1'b1;
    end else begin
      e.instr = mem_word(p);
      e.fault = 1'b0;
    end
    e.pc = p;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s observed=%h expected=%h at %0t", tag, observed,
               expected, $time);
    end
  endtask

  // One clock. Outputs are read #1 after the edge. A word accepted in the
  // previous cycle steps the PC model here, as program_counter would.
  task automatic tick();
    @(posedge clk);
    #1;
    if (adv_pending) begin
      pc = pc + 32'd4;
      sb.push_back(exp_for(pc));
      adv_pending = 1'b0;
    end
  endtask

  // Redirect: one flush cycle with the new PC. Everything in flight is dropped.
  task automatic applyStimulus(input logic [31:0] new_pc);
    flush = 1'b1;
    pc    = new_pc;
    sb.delete();
    sb.push_back(exp_for(new_pc));
    adv_pending = 1'b0;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_stb(input string tag, input logic [31:0] adr, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = mem_stb;
    end
    checkOutput({tag, "_stb_seen"}, 32'(seen), 32'd1);
    if (seen) checkOutput({tag, "_adr"}, mem_adr, adr);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = instr_valid;
    end
    checkOutput({tag, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_accept(input string tag, input int budget);
    int start = accept_count;
    for (int i = 0; i < budget && accept_count == start; i++) tick();
    checkOutput({tag, "_accepted"}, 32'(accept_count != start), 32'd1);
  endtask

  // Bus responder: ack after ack_delay wait cycles of a strobe.
  initial begin
    mem_ack   = 1'b0;
    mem_dat_r = 32'h0;
    wait_cnt  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_cyc && mem_stb) begin
        if (wait_cnt == ack_delay) begin
          mem_ack   = 1'b1;
          mem_dat_r = mem_word(mem_adr);
        end else begin
          mem_ack   = 1'b0;
          mem_dat_r = 32'h0;
        end
        wait_cnt++;
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // Scoreboard consumer: every accepted word must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (flush) checkOutput("no_count_on_flush", 32'(pc_count), 32'd0);
      if (pc_count) begin
        exp_t e;
        accept_count++;
        adv_pending = 1'b1;
        checkOutput("sb_has_entry", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checkOutput("instr", instr, e.instr);
          checkOutput("instr_pc", instr_pc, e.pc);
          checkOutput("instr_fault", 32'(instr_fault), 32'(e.fault));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc0;
    check_count  = 0;
    error_count  = 0;
    accept_count = 0;
    adv_pending  = 1'b0;
    ack_delay    = 0;
    reset        = 1'b1;
    reset_to     = 1'b1;
    pc           = 32'h0;
    flush        = 1'b0;
    instr_ready  = 1'b0;
    repeat (3) tick();

    // Reset state
    checkOutput("rst_cyc", 32'(mem_cyc), 32'd0);
    checkOutput("rst_stb", 32'(mem_stb), 32'd0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_fault", 32'(instr_fault), 32'd0);
    checkOutput("rst_adr", mem_adr, 32'h0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);

    // Basic fetch at minimum latency, then the next word at 0x4
    $display("[TB] basic fetch");
    sb.push_back(exp_for(32'h0));
    instr_ready = 1'b1;
    reset       = 1'b0;
    tick();
    checkOutput("basic_stb_n1", 32'(mem_stb), 32'd1);
    checkOutput("basic_adr_n1", mem_adr, 32'h0);
    tick();
    checkOutput("basic_valid_n2", 32'(instr_valid), 32'd1);
    wait_stb("basic_next", 32'h4, 8);
    wait_accept("basic_next", 8);
    ack_delay = 1;

    // Flush while waiting for ack: strobe held until ack, no word delivered
    $display("[TB] flush during request");
    ack_delay = 3;
    applyStimulus(32'h10);
    wait_stb("flush_first", 32'h10, 20);
    tick();
    flush = 1'b1;
    pc    = 32'h100;
    sb.delete();
    sb.push_back(exp_for(32'h100));
    checkOutput("flush_w2_valid", 32'(instr_valid), 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("flush_w3_stb", 32'(mem_stb), 32'd1);
    checkOutput("flush_w3_adr", mem_adr, 32'h10);
    checkOutput("flush_w3_valid", 32'(instr_valid), 32'd0);
    tick();
    checkOutput("flush_w4_stb", 32'(mem_stb), 32'd1);
    checkOutput("flush_w4_valid", 32'(instr_valid), 32'd0);
    tick();
    checkOutput("flush_done_stb", 32'(mem_stb), 32'd0);
    checkOutput("flush_done_valid", 32'(instr_valid), 32'd0);
    ack_delay = 1;
    wait_stb("flush_refetch", 32'h100, 8);
    wait_accept("flush_refetch", 8);

    // Misaligned PC: faulted NOP without a bus cycle
    $display("[TB] misaligned pc");
    instr_ready = 1'b0;
    wait_valid("mis_pre", 10);
    applyStimulus(32'h6);
    tick();
    checkOutput("mis_stb", 32'(mem_stb), 32'd0);
    checkOutput("mis_valid", 32'(instr_valid), 32'd1);
    checkOutput("mis_fault", 32'(instr_fault), 32'd1);
    instr_ready = 1'b1;
    wait_accept("mis", 4);

    // Back-pressure: held word stays put, no pc_count, no new strobe
    $display("[TB] back-pressure");
    instr_ready = 1'b0;
    applyStimulus(32'h200);
    wait_valid("bp", 20);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_instr", instr, mem_word(32'h200));
      checkOutput("bp_instr_pc", instr_pc, 32'h200);
      checkOutput("bp_valid", 32'(instr_valid), 32'd1);
      checkOutput("bp_stb", 32'(mem_stb), 32'd0);
      checkOutput("bp_pc_count", 32'(pc_count), 32'd0);
      tick();
    end
    acc0 = accept_count;
    instr_ready = 1'b1;
    tick();
    checkOutput("bp_one_accept", 32'(accept_count - acc0), 32'd1);
    tick();
    tick();
    checkOutput("bp_still_one", 32'(accept_count - acc0), 32'd1);

    // Timeout on the short-timeout instance: strobe for exactly 4 cycles
    $display("[TB] bus timeout");
    instr_ready = 1'b0;
    applyStimulus(32'h300);
    reset_to = 1'b0;
    begin
      int stb_cycles = 0;
      for (int i = 0; i < 20 && !instr_valid_to; i++) begin
        tick();
        if (mem_stb_to) stb_cycles++;
        if (mem_stb_to) checkOutput("to_adr", mem_adr_to, 32'h300);
      end
      checkOutput("to_stb_cycles", 32'(stb_cycles), 32'd4);
    end
    checkOutput("to_valid", 32'(instr_valid_to), 32'd1);
    checkOutput("to_fault", 32'(instr_fault_to), 32'd1);
    checkOutput("to_instr", instr_to, NOP);
    checkOutput("to_instr_pc", instr_pc_to, 32'h300);
    checkOutput("to_cyc", 32'(mem_cyc_to), 32'd0);
    checkOutput("to_pc_count", 32'(pc_count_to), 32'd0);
    reset_to = 1'b1;
    instr_ready = 1'b1;
    wait_accept("to_main", 20);

    // Reset in the middle of a request, then restart at the current PC
    $display("[TB] reset during request");
    instr_ready = 1'b0;
    wait_valid("rq_pre", 20);
    ack_delay = 1000;
    applyStimulus(32'h400);
    wait_stb("rq", 32'h400, 8);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("rq_cyc", 32'(mem_cyc), 32'd0);
    checkOutput("rq_stb", 32'(mem_stb), 32'd0);
    checkOutput("rq_valid", 32'(instr_valid), 32'd0);
    checkOutput("rq_instr_pc", instr_pc, 32'h0);
    reset = 1'b0;
    sb.delete();
    sb.push_back(exp_for(32'h400));
    adv_pending = 1'b0;
    ack_delay   = 1;
    instr_ready = 1'b1;
    wait_stb("rq_restart", 32'h400, 8);
    wait_accept("rq_restart", 8);
    instr_ready = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule
